// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-transaction sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, RUN, WAIT_END, DONE} seq_state_t;

  // Op counter holds up to MAX_LEN+1 = 16 ops.
  localparam int OP_W        = 5;
  localparam int TIMEOUT_48M = 2400000;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (len == 4'd0) return 4'd1;
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/i2c_busy_edge.sv
// Registers the i2c_master busy flag and flags its rising/falling edges.
module i2c_busy_edge (
  input  logic clk48,
  input  logic reset_n,
  input  logic busy,
  output logic rise,
  output logic fall
);
  logic busy_last;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) busy_last <= 1'b0;
    else          busy_last <= busy;
  end

  assign rise = busy & ~busy_last;
  assign fall = ~busy & busy_last;
endmodule

// File: rtl/i2c_reg_sequencer.sv
// Runs a full register write or read (index write + repeated-start read) on the
// byte-level i2c_master, one command at a time, with NACK/timeout status.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_48M
) (
  input  logic                 clk48,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [6:0]           cmd_dev,
  input  logic                 cmd_rw,
  input  logic [7:0]           cmd_reg,
  input  logic [3:0]           cmd_len,
  input  logic [8*MAX_LEN-1:0] cmd_wdata,
  output logic                 rsp_done,
  output logic                 rsp_error,
  output logic [8*MAX_LEN-1:0] rsp_rdata,
  output logic                 m_ena,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_data_wr,
  input  logic                 m_busy,
  input  logic [7:0]           m_data_rd,
  input  logic                 m_ack_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t           state, state_n;
  logic                 out_of_reset;
  logic                 rise, fall, accept, busy_st, timeout;
  logic [6:0]           dev_q;
  logic                 rw_q;
  logic [7:0]           reg_q;
  logic [3:0]           n_q;
  logic [8*MAX_LEN-1:0] wdata_q;
  logic [OP_W-1:0]      k, k_inc, t_ops;
  logic [TW-1:0]        tcnt;
  logic                 err;
  int                   wr_idx, rd_idx, last_idx;

  i2c_busy_edge u_edge (
    .clk48   (clk48),
    .reset_n (reset_n),
    .busy    (m_busy),
    .rise    (rise),
    .fall    (fall)
  );

  assign cmd_ready = out_of_reset && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy_st   = (state == WAIT_IDLE) || (state == RUN) || (state == WAIT_END);
  assign timeout   = busy_st && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign k_inc     = k + OP_W'(1);
  assign t_ops     = OP_W'(n_q) + OP_W'(1);
  assign wr_idx    = int'(k_inc) - 1;
  assign rd_idx    = int'(k_inc) - 3;
  assign last_idx  = int'(n_q) - 1;
  assign rsp_done  = (state == DONE);
  assign rsp_error = (state == DONE) && err;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Timeout is checked first in every busy state so it beats a same-cycle edge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept) state_n = WAIT_IDLE;
      WAIT_IDLE: if (timeout) state_n = DONE;
                 else if (!m_busy) state_n = RUN;
      RUN:       if (timeout) state_n = DONE;
                 else if (rise && k_inc == t_ops) state_n = WAIT_END;
      WAIT_END:  if (timeout || fall) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      out_of_reset <= 1'b0;
      dev_q        <= '0;
      rw_q         <= 1'b0;
      reg_q        <= '0;
      n_q          <= '0;
      wdata_q      <= '0;
      k            <= '0;
      tcnt         <= '0;
      err          <= 1'b0;
      rsp_rdata    <= '0;
      m_ena        <= 1'b0;
      m_addr       <= '0;
      m_rw         <= 1'b0;
      m_data_wr    <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (busy_st) begin
        tcnt <= tcnt + TW'(1);
        if ((rise || fall) && m_ack_error) err <= 1'b1;
      end
      case (state)
        IDLE: if (accept) begin
          dev_q   <= cmd_dev;
          rw_q    <= cmd_rw;
          reg_q   <= cmd_reg;
          n_q     <= clamp_len(cmd_len, MAX_LEN);
          wdata_q <= cmd_wdata;
          k       <= '0;
          tcnt    <= '0;
          err     <= 1'b0;
        end
        WAIT_IDLE: if (timeout) begin
          m_ena <= 1'b0;
          err   <= 1'b1;
        end else if (!m_busy) begin
          m_ena     <= 1'b1;
          m_addr    <= dev_q;
          m_rw      <= 1'b0;
          m_data_wr <= reg_q;
          k         <= '0;
        end
        // Each rise means the master latched op k; queue the next one behind it.
        RUN: if (timeout) begin
          m_ena <= 1'b0;
          err   <= 1'b1;
        end else if (rise) begin
          k <= k_inc;
          if (k_inc == t_ops) m_ena <= 1'b0;
          else begin
            m_rw <= rw_q;
            if (!rw_q) m_data_wr <= wdata_q[8*wr_idx +: 8];
          end
          if (rw_q && k_inc >= OP_W'(3)) rsp_rdata[8*rd_idx +: 8] <= m_data_rd;
        end
        WAIT_END: if (timeout) begin
          m_ena <= 1'b0;
          err   <= 1'b1;
        end else if (fall && rw_q) begin
          rsp_rdata[8*last_idx +: 8] <= m_data_rd;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Sequences the byte-level i2c_master (ena/busy handshake) to run complete register transactions on the MEGAphone I2C bus.
- Each transaction is a register write (device address, register index, 1..MAX_LEN data bytes) or a register read (register-index write, repeated start, 1..MAX_LEN read bytes).
- It replaces ad-hoc busy-edge FSMs in top-level glue. One command is in flight at a time; results are returned as a parallel word with done/error status.

Parameters:
- MAX_LEN, 4, maximum data bytes per transaction (1..15).
- TIMEOUT_CYCLES, 2400000, cycles a transaction may take before being aborted (50 ms at 48 MHz).

Ports:
- clk48  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready.
- cmd_dev  in  7  7-bit device address.
- cmd_rw  in  1  1 = register read, 0 = register write.
- cmd_reg  in  8  register index.
- cmd_len  in  4  data byte count; 0 is treated as 1, values >MAX_LEN are clamped to MAX_LEN.
- cmd_wdata  in  8*MAX_LEN  write bytes; byte i is at [8i+7:8i].
- rsp_done  out  1  one-cycle pulse at transaction end.
- rsp_error  out  1  valid with rsp_done: NACK or timeout.
- rsp_rdata  out  8*MAX_LEN  read bytes, same packing; holds until next read completes.
- m_ena  out  1  to i2c_master ena.
- m_addr  out  7  to i2c_master addr.
- m_rw  out  1  to i2c_master rw.
- m_data_wr  out  8  to i2c_master data_wr.
- m_busy  in  1  from i2c_master busy.
- m_data_rd  in  8  from i2c_master data_rd.
- m_ack_error  in  1  from i2c_master ack_error.

Behaviour:
- Reset values: cmd_ready=0 until IDLE is entered (first cycle after reset release); rsp_done=0, rsp_error=0, rsp_rdata=0, m_ena=0, m_addr=0, m_rw=0, m_data_wr=0. State=IDLE, all counters 0.
- Command latching: on acceptance, the sequencer latches all cmd_* fields. N = clamped length. Total ops T = N+1. Op 1 is always a write of cmd_reg. Ops 2..T are writes of wdata[i] for cmd_rw=0, or reads for cmd_rw=1.
- Edge detection: busy_last is registered every cycle. rise = m_busy && !busy_last; fall = !m_busy && busy_last.
- IDLE: cmd_ready=1. On accept -> WAIT_IDLE.
- WAIT_IDLE: waits until m_busy=0, then drives m_ena=1, m_addr=dev, m_rw=0, m_data_wr=reg, sets k=0 -> RUN.
- RUN, on each rise, with k incremented (k = op now latched by master):
  - If k==T: m_ena<=0 -> WAIT_END.
  - Otherwise, present op k+1. m_addr is unchanged. m_rw=cmd_rw for ops >=2. m_data_wr=wdata[k-1] for writes.
  - Read capture: if cmd_rw=1 and k>=3, capture m_data_rd into rsp_rdata byte k-3.
- WAIT_END: on fall, if read, capture m_data_rd into byte N-1. Then -> DONE.
- DONE: for one cycle, rsp_done=1 and rsp_error = sticky error. -> IDLE.
- Error: m_ack_error sampled high on any rise or fall sets a sticky error flag (cleared on accept).
  - The transaction continues to the master's natural end; the sequencer does not truncate it.
  - rsp_rdata bytes already written are kept.
  - Bytes from a transaction flagged with error are undefined to software.
- Timeout: a cycle counter runs in WAIT_IDLE/RUN/WAIT_END. At TIMEOUT_CYCLES: m_ena<=0, error=1 -> DONE.
- Simultaneous events: rise and timeout in the same cycle -> timeout wins. cmd_valid outside IDLE is ignored (no queue).
- Reset mid-transaction: all outputs return to reset values immediately (async). The master is reset by the same reset_n at the top level.

Decomposition:
- Package i2c_seq_pkg: state enum (IDLE, WAIT_IDLE, RUN, WAIT_END, DONE), op-count width localparam, and the default timeout constant for 48 MHz.
- Sub-module i2c_busy_edge: registers busy and produces rise/fall pulses. It is reusable by other I2C glue.
- The byte counter and timeout counter stay inline.

Test Plan:
- Write: dev=0x25, reg=0x03, len=2, wdata=0xA55A. Master model must see ops reg 0x03, then 0x5A, then 0xA5, all rw=0. m_ena must drop on the 3rd busy rise. rsp_done=1 and rsp_error=0 once.
- Read: dev=0x25, reg=0x00, len=3, model returns 0x11, 0x22, 0x33. rsp_rdata[23:0]=0x332211, rsp_error=0. The op-2 rw transition must be 0->1 (repeated start).
- NACK: model asserts ack_error after the address byte. Transaction runs to the busy fall, then rsp_done with rsp_error=1. A following command is accepted normally.
- Timeout: model holds busy=1 forever. Expect m_ena=0 and rsp_done with rsp_error=1 exactly TIMEOUT_CYCLES (overridden to 100) after accept.
- len=0 and len=9 with MAX_LEN=4: one byte and four bytes transferred respectively.
- Assert reset_n low during RUN of a read. Outputs are zero the same cycle; after release, cmd_ready=1 and a fresh read completes correctly.
